// File: rtl/modport_decoder_if.sv
// Decode-stage bundle: instruction in, registered decode out.
// master drives the instruction side, slave is the decoder.
interface modport_decoder_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
);
    logic                  i_stall;
    logic                  i_flush;
    logic [ADDR_WIDTH-1:0] i_pc;
    logic                  i_inst_valid;
    logic [31:0]           i_inst_data;
    logic                  o_valid;
    logic                  o_illegal;
    logic [4:0]            o_alu_ctl;
    logic                  o_is_branch_jump;
    logic                  o_is_jump;
    logic                  o_is_jump_reg;
    logic [ADDR_WIDTH-1:0] o_branch_target;
    logic                  o_is_mem_access;
    logic                  o_mem_action;
    logic                  o_is_ll;
    logic                  o_is_sc;
    logic                  o_is_sw;
    logic                  o_uses_rs;
    logic                  o_uses_rt;
    logic                  o_uses_rw;
    logic [4:0]            o_rs_addr;
    logic [4:0]            o_rt_addr;
    logic [4:0]            o_rw_addr;
    logic                  o_uses_immediate;
    logic [DATA_WIDTH-1:0] o_immediate;

    modport master (
        output i_stall, i_flush, i_pc, i_inst_valid, i_inst_data,
        input  o_valid, o_illegal, o_alu_ctl,
        input  o_is_branch_jump, o_is_jump, o_is_jump_reg,
        input  o_branch_target,
        input  o_is_mem_access, o_mem_action,
        input  o_is_ll, o_is_sc, o_is_sw,
        input  o_uses_rs, o_uses_rt, o_uses_rw,
        input  o_rs_addr, o_rt_addr, o_rw_addr,
        input  o_uses_immediate, o_immediate
    );

    modport slave (
        input  i_stall, i_flush, i_pc, i_inst_valid, i_inst_data,
        output o_valid, o_illegal, o_alu_ctl,
        output o_is_branch_jump, o_is_jump, o_is_jump_reg,
        output o_branch_target,
        output o_is_mem_access, o_mem_action,
        output o_is_ll, o_is_sc, o_is_sw,
        output o_uses_rs, o_uses_rt, o_uses_rw,
        output o_rs_addr, o_rt_addr, o_rw_addr,
        output o_uses_immediate, o_immediate
    );
endinterface

// File: rtl/modport_decoder.sv
// Registered MIPS-I instruction decoder for the mips_core decode stage.
// Outputs follow the instruction presented on the previous clock edge.
module modport_decoder #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
) (
    input logic              clk,
    input logic              rst_n,
    modport_decoder_if.slave dec
);
    typedef enum logic [4:0] {
        NOP = 5'd0, ADD = 5'd1, ADDU = 5'd2, SUB = 5'd3,
        SUBU = 5'd4, AND = 5'd5, OR = 5'd6, XOR = 5'd7,
        NOR = 5'd8, SLL = 5'd9, SRL = 5'd10, SRA = 5'd11,
        SLLV = 5'd12, SRLV = 5'd13, SRAV = 5'd14, SLT = 5'd15,
        SLTU = 5'd16, BEQ = 5'd17, BNE = 5'd18, BLEZ = 5'd19,
        BGTZ = 5'd20, BGEZ = 5'd21, BLTZ = 5'd22,
        MTC0_PASS = 5'd23, MTC0_FAIL = 5'd24, MTC0_DONE = 5'd25
    } alu_t;

    typedef struct packed {
        logic                  valid;
        logic                  illegal;
        logic [4:0]            alu;
        logic                  bj;
        logic                  jump;
        logic                  jump_reg;
        logic [ADDR_WIDTH-1:0] target;
        logic                  mem;
        logic                  write;
        logic                  ll;
        logic                  sc;
        logic                  sw;
        logic [4:0]            rs;
        logic [4:0]            rt;
        logic [4:0]            rw;
        logic                  uses_imm;
        logic [DATA_WIDTH-1:0] imm;
    } dec_t;

    dec_t nx, q;

    logic [31:0]           d;
    logic [5:0]            op;
    logic [5:0]            fn;
    logic signed [31:0]    sext;
    logic [31:0]           zext;
    logic [31:0]           shamt;
    logic [ADDR_WIDTH-1:0] pc8;
    logic [ADDR_WIDTH-1:0] btarget;
    logic [ADDR_WIDTH-1:0] jtarget;

    assign d       = dec.i_inst_data;
    assign op      = d[31:26];
    assign fn      = d[5:0];
    assign sext    = {{16{d[15]}}, d[15:0]};
    assign zext    = {16'h0, d[15:0]};
    assign shamt   = {27'h0, d[10:6]};
    assign pc8     = dec.i_pc + ADDR_WIDTH'(8);
    assign btarget = dec.i_pc + ADDR_WIDTH'(4) + ADDR_WIDTH'(sext <<< 2);
    assign jtarget = {d[ADDR_WIDTH-3:0], 2'b00};

    always_comb begin
        nx       = '0;
        nx.valid = dec.i_inst_valid;
        if (dec.i_inst_valid) begin
            unique case (op)
                6'h00: begin
                    nx.rs = d[25:21];
                    nx.rt = d[20:16];
                    nx.rw = d[15:11];
                    unique case (fn)
                        6'h20: nx.alu = ADD;
                        6'h21: nx.alu = ADDU;
                        6'h22: nx.alu = SUB;
                        6'h23: nx.alu = SUBU;
                        6'h24: nx.alu = AND;
                        6'h25: nx.alu = OR;
                        6'h26: nx.alu = XOR;
                        6'h27: nx.alu = NOR;
                        6'h04: nx.alu = SLLV;
                        6'h06: nx.alu = SRLV;
                        6'h07: nx.alu = SRAV;
                        6'h2a: nx.alu = SLT;
                        6'h2b: nx.alu = SLTU;
                        6'h00, 6'h02, 6'h03: begin
                            nx.alu      = (fn == 6'h00) ? SLL :
                                          (fn == 6'h02) ? SRL : SRA;
                            // shifts read their source from the rt field
                            nx.rs       = d[20:16];
                            nx.rt       = '0;
                            nx.uses_imm = 1'b1;
                            nx.imm      = DATA_WIDTH'(shamt);
                        end
                        6'h08: begin
                            nx.alu      = NOP;
                            nx.rt       = '0;
                            nx.rw       = '0;
                            nx.bj       = 1'b1;
                            nx.jump     = 1'b1;
                            nx.jump_reg = 1'b1;
                        end
                        6'h09: begin
                            nx.alu      = OR;
                            nx.rt       = '0;
                            nx.rw       = 5'd31;
                            nx.uses_imm = 1'b1;
                            nx.imm      = DATA_WIDTH'(pc8);
                            nx.bj       = 1'b1;
                            nx.jump     = 1'b1;
                            nx.jump_reg = 1'b1;
                        end
                        default: begin
                            nx          = '0;
                            nx.illegal  = 1'b1;
                        end
                    endcase
                end
                6'h08, 6'h09, 6'h0a, 6'h0b: begin
                    nx.alu      = (op == 6'h08) ? ADD :
                                  (op == 6'h09) ? ADDU :
                                  (op == 6'h0a) ? SLT : SLTU;
                    nx.rs       = d[25:21];
                    nx.rw       = d[20:16];
                    nx.uses_imm = 1'b1;
                    nx.imm      = DATA_WIDTH'(sext);
                end
                6'h0c, 6'h0d, 6'h0e: begin
                    nx.alu      = (op == 6'h0c) ? AND :
                                  (op == 6'h0d) ? OR : XOR;
                    nx.rs       = d[25:21];
                    nx.rw       = d[20:16];
                    nx.uses_imm = 1'b1;
                    nx.imm      = DATA_WIDTH'(zext);
                end
                6'h0f: begin
                    nx.alu      = OR;
                    nx.rw       = d[20:16];
                    nx.uses_imm = 1'b1;
                    nx.imm      = DATA_WIDTH'({d[15:0], 16'h0});
                end
                6'h01, 6'h04, 6'h05, 6'h06, 6'h07: begin
                    unique case (op)
                        6'h04:   nx.alu = BEQ;
                        6'h05:   nx.alu = BNE;
                        6'h06:   nx.alu = BLEZ;
                        6'h07:   nx.alu = BGTZ;
                        default: nx.alu = d[16] ? BGEZ : BLTZ;
                    endcase
                    nx.rs     = d[25:21];
                    nx.rt     = d[20:16];
                    nx.bj     = 1'b1;
                    nx.target = btarget;
                end
                6'h02: begin
                    nx.alu    = NOP;
                    nx.bj     = 1'b1;
                    nx.jump   = 1'b1;
                    nx.target = jtarget;
                end
                6'h03: begin
                    nx.alu      = OR;
                    nx.rw       = 5'd31;
                    nx.uses_imm = 1'b1;
                    nx.imm      = DATA_WIDTH'(pc8);
                    nx.bj       = 1'b1;
                    nx.jump     = 1'b1;
                    nx.target   = jtarget;
                end
                6'h23, 6'h2b, 6'h30, 6'h38: begin
                    nx.alu      = ADD;
                    nx.mem      = 1'b1;
                    nx.write    = (op == 6'h2b) || (op == 6'h38);
                    nx.sw       = (op == 6'h2b);
                    nx.ll       = (op == 6'h30);
                    nx.sc       = (op == 6'h38);
                    nx.rs       = d[25:21];
                    nx.rt       = (op == 6'h2b) ? d[20:16] : 5'd0;
                    nx.rw       = (op == 6'h2b) ? 5'd0 : d[20:16];
                    nx.uses_imm = 1'b1;
                    nx.imm      = DATA_WIDTH'(sext);
                end
                6'h10: begin
                    nx.rt = d[20:16];
                    unique case (d[15:11])
                        5'd17:   nx.alu = MTC0_PASS;
                        5'd18:   nx.alu = MTC0_FAIL;
                        5'd19:   nx.alu = MTC0_DONE;
                        default: begin
                            nx         = '0;
                            nx.illegal = 1'b1;
                        end
                    endcase
                end
                default: begin
                    nx         = '0;
                    nx.illegal = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             q <= '0;
        else if (dec.i_flush)   q <= '0;
        else if (!dec.i_stall)  q <= nx;
    end

    assign dec.o_valid          = q.valid;
    assign dec.o_illegal        = q.illegal;
    assign dec.o_alu_ctl        = q.alu;
    assign dec.o_is_branch_jump = q.bj;
    assign dec.o_is_jump        = q.jump;
    assign dec.o_is_jump_reg    = q.jump_reg;
    assign dec.o_branch_target  = q.target;
    assign dec.o_is_mem_access  = q.mem;
    assign dec.o_mem_action     = q.write;
    assign dec.o_is_ll          = q.ll;
    assign dec.o_is_sc          = q.sc;
    assign dec.o_is_sw          = q.sw;
    assign dec.o_uses_rs        = |q.rs;
    assign dec.o_uses_rt        = |q.rt;
    assign dec.o_uses_rw        = |q.rw;
    assign dec.o_rs_addr        = q.rs;
    assign dec.o_rt_addr        = q.rt;
    assign dec.o_rw_addr        = q.rw;
    assign dec.o_uses_immediate = q.uses_imm;
    assign dec.o_immediate      = q.imm;
endmodule

// File: tb/tb_modport_decoder.sv
// Directed bench for modport_decoder: hand-encoded MIPS words,
// hand-computed expected decode, plus stall/flush/async reset.
module tb_modport_decoder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    modport_decoder_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus ();

    modport_decoder #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .dec   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [15:0] pc, input logic [31:0] inst);
        bus.i_pc         = pc;
        bus.i_inst_data  = inst;
        bus.i_inst_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.i_stall      = 1'b0;
        bus.i_flush      = 1'b0;
        bus.i_pc         = '0;
        bus.i_inst_valid = 1'b0;
        bus.i_inst_data  = '0;
        #1;
        chk("rst_valid", bus.o_valid, 0);
        chk("rst_alu", bus.o_alu_ctl, 0);
        chk("rst_imm", bus.o_immediate, 0);
        chk("rst_illegal", bus.o_illegal, 0);
        @(negedge clk);
        rst_n = 1'b1;

        issue(16'h0000, 32'h0022_1820);
        chk("add_valid", bus.o_valid, 1);
        chk("add_alu", bus.o_alu_ctl, 1);
        chk("add_rs", bus.o_rs_addr, 1);
        chk("add_rt", bus.o_rt_addr, 2);
        chk("add_rw", bus.o_rw_addr, 3);
        chk("add_uses", {bus.o_uses_rs, bus.o_uses_rt, bus.o_uses_rw}, 3'b111);
        chk("add_uimm", bus.o_uses_immediate, 0);

        issue(16'h0100, 32'h1022_FFFF);
        chk("beq_alu", bus.o_alu_ctl, 17);
        chk("beq_bj", bus.o_is_branch_jump, 1);
        chk("beq_tgt", bus.o_branch_target, 16'h0100);
        chk("beq_urw", bus.o_uses_rw, 0);
        chk("beq_jump", bus.o_is_jump, 0);

        issue(16'h0040, 32'h0C00_0040);
        chk("jal_alu", bus.o_alu_ctl, 6);
        chk("jal_rw", bus.o_rw_addr, 31);
        chk("jal_imm", bus.o_immediate, 32'h48);
        chk("jal_tgt", bus.o_branch_target, 16'h0100);
        chk("jal_jump", {bus.o_is_jump, bus.o_is_jump_reg}, 2'b10);

        issue(16'h0000, 32'h8CC5_FFFC);
        chk("lw_mem", bus.o_is_mem_access, 1);
        chk("lw_act", bus.o_mem_action, 0);
        chk("lw_imm", bus.o_immediate, 32'hFFFF_FFFC);
        chk("lw_regs", {bus.o_rs_addr, bus.o_rw_addr}, {5'd6, 5'd5});

        issue(16'h0000, 32'hACC5_0008);
        chk("sw_act", bus.o_mem_action, 1);
        chk("sw_flag", bus.o_is_sw, 1);
        chk("sw_urw", bus.o_uses_rw, 0);
        chk("sw_rt", bus.o_rt_addr, 5);
        chk("sw_imm", bus.o_immediate, 32'h8);

        issue(16'h0000, 32'h0000_0000);
        chk("sll_valid", bus.o_valid, 1);
        chk("sll_alu", bus.o_alu_ctl, 9);
        chk("sll_uses", {bus.o_uses_rs, bus.o_uses_rw}, 2'b00);

        issue(16'h0000, 32'hFC00_0000);
        chk("bad_op", {bus.o_valid, bus.o_illegal}, 2'b01);

        issue(16'h0000, 32'h0022_0018);
        chk("mult_ill", {bus.o_valid, bus.o_illegal}, 2'b01);

        issue(16'h0000, 32'h03E0_0008);
        chk("jr_flags", {bus.o_is_branch_jump, bus.o_is_jump, bus.o_is_jump_reg}, 3'b111);
        chk("jr_rs", bus.o_rs_addr, 31);
        chk("jr_alu", bus.o_alu_ctl, 0);

        issue(16'h0000, 32'h3422_8000);
        chk("ori_imm", bus.o_immediate, 32'h0000_8000);
        chk("ori_alu", bus.o_alu_ctl, 6);

        issue(16'h0000, 32'h3C04_1234);
        chk("lui_imm", bus.o_immediate, 32'h1234_0000);
        chk("lui_urs", bus.o_uses_rs, 0);

        issue(16'h0200, 32'h0421_0002);
        chk("bgez_alu", bus.o_alu_ctl, 21);
        chk("bgez_tgt", bus.o_branch_target, 16'h020C);

        issue(16'h0000, 32'h0420_0002);
        chk("bltz_alu", bus.o_alu_ctl, 22);

        issue(16'h0000, 32'h4001_8800);
        chk("mtc0_alu", bus.o_alu_ctl, 23);
        chk("mtc0_rt", {bus.o_uses_rt, bus.o_rt_addr}, {1'b1, 5'd1});

        issue(16'h0000, 32'h4001_2800);
        chk("mtc0_ill", {bus.o_valid, bus.o_illegal}, 2'b01);

        bus.i_inst_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("inv_valid", {bus.o_valid, bus.o_illegal, bus.o_alu_ctl}, 0);

        issue(16'h0000, 32'hACC5_0008);
        bus.i_stall = 1'b1;
        issue(16'h0000, 32'h0022_1820);
        chk("stall_sw", bus.o_is_sw, 1);
        chk("stall_rw", bus.o_rw_addr, 0);

        bus.i_stall = 1'b0;
        bus.i_flush = 1'b1;
        issue(16'h0000, 32'h0022_1820);
        chk("flush_valid", bus.o_valid, 0);
        chk("flush_mem", bus.o_is_mem_access, 0);

        bus.i_flush = 1'b0;
        issue(16'h0000, 32'h0022_1820);
        chk("post_valid", bus.o_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", bus.o_valid, 0);
        chk("arst_rs", bus.o_rs_addr, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
